// File: rtl/modbus_rtu_master_tx.sv
// Modbus RTU request framer: latches one request, runs CRC-16/MODBUS one bit per clock,
// streams the 8-byte frame to a UART byte interface, then holds off for the inter-frame silence.
module modbus_rtu_master_tx #(
    parameter int GAP_CYCLES = 200521,
    parameter int GAP_W      = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_dev_addr,
    input  logic [7:0]  req_func,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        tx_idle,
    output logic        frame_done,
    output logic [15:0] frame_crc,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CALC, SEND, GAP} state_t;

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t           state_reg;
    logic [47:0]      frame_reg;
    logic [15:0]      crc_reg;
    logic [5:0]       bit_cnt_reg;
    logic [2:0]       byte_idx_reg;
    logic [GAP_W-1:0] gap_cnt_reg;

    logic [7:0]       calc_byte;
    logic [7:0]       next_byte;
    logic [15:0]      crc_mix;
    logic [15:0]      crc_step;
    logic [2:0]       next_idx;

    always_comb begin
        case (bit_cnt_reg[5:3])
            3'd0:    calc_byte = frame_reg[47:40];
            3'd1:    calc_byte = frame_reg[39:32];
            3'd2:    calc_byte = frame_reg[31:24];
            3'd3:    calc_byte = frame_reg[23:16];
            3'd4:    calc_byte = frame_reg[15:8];
            3'd5:    calc_byte = frame_reg[7:0];
            default: calc_byte = 8'h00;
        endcase
        // A new message byte is folded into the low CRC byte on the first bit step of that byte.
        crc_mix  = (bit_cnt_reg[2:0] == 3'd0) ? (crc_reg ^ {8'h00, calc_byte}) : crc_reg;
        crc_step = crc_mix[0] ? ((crc_mix >> 1) ^ 16'hA001) : (crc_mix >> 1);

        next_idx = byte_idx_reg + 3'd1;
        case (next_idx)
            3'd0:    next_byte = frame_reg[47:40];
            3'd1:    next_byte = frame_reg[39:32];
            3'd2:    next_byte = frame_reg[31:24];
            3'd3:    next_byte = frame_reg[23:16];
            3'd4:    next_byte = frame_reg[15:8];
            3'd5:    next_byte = frame_reg[7:0];
            3'd6:    next_byte = crc_reg[7:0];
            default: next_byte = crc_reg[15:8];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= GAP;
            frame_reg    <= '0;
            crc_reg      <= '0;
            bit_cnt_reg  <= '0;
            byte_idx_reg <= '0;
            gap_cnt_reg  <= '0;
            req_ready    <= 1'b0;
            tx_valid     <= 1'b0;
            tx_data      <= 8'h00;
            frame_done   <= 1'b0;
            frame_crc    <= 16'h0000;
            busy         <= 1'b1;
        end else begin
            frame_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        frame_reg   <= {req_dev_addr, req_func, req_addr, req_data};
                        crc_reg     <= 16'hFFFF;
                        bit_cnt_reg <= '0;
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                        state_reg   <= CALC;
                    end
                end
                CALC: begin
                    // 48 bit steps, then one cycle to present the first byte.
                    if (bit_cnt_reg == 6'd48) begin
                        tx_data      <= frame_reg[47:40];
                        tx_valid     <= 1'b1;
                        byte_idx_reg <= '0;
                        state_reg    <= SEND;
                    end else begin
                        crc_reg     <= crc_step;
                        bit_cnt_reg <= bit_cnt_reg + 6'd1;
                    end
                end
                SEND: begin
                    if (tx_valid && tx_ready) begin
                        if (byte_idx_reg == 3'd7) begin
                            tx_valid    <= 1'b0;
                            frame_done  <= 1'b1;
                            frame_crc   <= crc_reg;
                            gap_cnt_reg <= '0;
                            state_reg   <= GAP;
                        end else begin
                            tx_data      <= next_byte;
                            byte_idx_reg <= next_idx;
                        end
                    end
                end
                GAP: begin
                    // Silence is measured on the line, so any UART activity restarts the count.
                    if (!tx_idle) begin
                        gap_cnt_reg <= '0;
                    end else if (gap_cnt_reg == GAP_LAST) begin
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_modbus_rtu_master_tx.sv
// Directed bench for modbus_rtu_master_tx: table of requests with known Modbus CRCs,
// plus hand sequences for reset gap, tx_idle restart and mid-frame reset.
module tb_modbus_rtu_master_tx;

    localparam int GAP = 20;

    typedef struct {
        logic [7:0]  dev;
        logic [7:0]  func;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] crc;        // {hi,lo}: lo byte goes on the wire first
        bit          rand_rdy;
        bit          junk;       // keep req_valid high with other fields during the frame
        bit          idle_pulse; // drop tx_idle for 5 cycles mid-gap before this request
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_dev_addr = 8'h00;
    logic [7:0]  req_func = 8'h00;
    logic [15:0] req_addr = 16'h0000;
    logic [15:0] req_data = 16'h0000;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        tx_idle = 1'b1;
    logic        frame_done;
    logic [15:0] frame_crc;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_pulses = 0;

    vec_t vecs[5];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (frame_done) done_pulses <= done_pulses + 1;

    modbus_rtu_master_tx #(.GAP_CYCLES(GAP), .GAP_W(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_dev_addr(req_dev_addr),
        .req_func(req_func),
        .req_addr(req_addr),
        .req_data(req_data),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_idle(tx_idle),
        .frame_done(frame_done),
        .frame_crc(frame_crc),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input vec_t v, input int idx);
        case (idx)
            0:       return v.dev;
            1:       return v.func;
            2:       return v.addr[15:8];
            3:       return v.addr[7:0];
            4:       return v.data[15:8];
            5:       return v.data[7:0];
            6:       return v.crc[7:0];
            default: return v.crc[15:8];
        endcase
    endfunction

    // Issues one request and follows it through CALC and SEND. With abort_after > 0 it
    // returns at the negedge following that many byte handshakes.
    task automatic run_frame(input vec_t v, input bit check_gap, input int gap_ref,
                             input int abort_after, output int done_cyc);
        int         lat;
        int         nb;
        bit         seen_ready;
        bit         seen_done;
        bit         held;
        bit         ready_leak;
        logic [7:0] held_byte;

        @(negedge clk);
        req_dev_addr = v.dev;
        req_func     = v.func;
        req_addr     = v.addr;
        req_data     = v.data;
        req_valid    = 1'b1;
        seen_ready   = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (req_ready) begin
                seen_ready = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("req_ready_seen", 32'(seen_ready), 32'd1);
        if (!seen_ready) begin
            req_valid = 1'b0;
            done_cyc  = cyc;
            return;
        end
        if (check_gap) chk("gap_length", 32'(cyc - gap_ref), 32'(GAP));

        @(posedge clk);
        #1;
        req_valid    = v.junk;
        req_dev_addr = ~v.dev;
        req_func     = ~v.func;
        req_addr     = ~v.addr;
        req_data     = v.data ^ 16'h5A5A;
        chk("busy_after_accept", 32'(busy), 32'd1);

        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (tx_valid) begin
                lat = c;
                break;
            end
        end
        chk("tx_valid_latency", 32'(lat), 32'd49);

        nb = 0;
        held = 1'b0;
        held_byte = 8'h00;
        seen_done = 1'b0;
        ready_leak = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (req_ready) ready_leak = 1'b1;
            if (frame_done) begin
                seen_done = 1'b1;
                break;
            end
            if (held) begin
                chk("byte_held", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, held_byte});
                held = 1'b0;
            end
            if (abort_after > 0 && nb == abort_after) break;
            tx_ready = v.rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid) begin
                if (tx_ready) begin
                    chk($sformatf("byte%0d", nb), 32'(tx_data), 32'(exp_byte(v, nb)));
                    nb++;
                end else begin
                    held = 1'b1;
                    held_byte = tx_data;
                end
            end
        end

        done_cyc = cyc;
        req_valid = 1'b0;
        if (abort_after > 0) begin
            chk("abort_bytes", 32'(nb), 32'(abort_after));
            return;
        end
        chk("frame_done_seen", 32'(seen_done), 32'd1);
        chk("byte_count", 32'(nb), 32'd8);
        chk("tx_valid_after_done", 32'(tx_valid), 32'd0);
        chk("frame_crc", 32'(frame_crc), 32'(v.crc));
        chk("req_ready_during_frame", 32'(ready_leak), 32'd0);
        $display("frame dev=%02h func=%02h addr=%04h data=%04h crc=%04h bytes=%0d",
                 v.dev, v.func, v.addr, v.data, frame_crc, nb);
        @(negedge clk);
        chk("frame_done_width", 32'(frame_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  gap_ref;
        int  dcyc;
        int  pulses_before;
        bit  ready_seen;

        vecs[0] = '{8'h01, 8'h03, 16'h0000, 16'h000A, 16'hCDC5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 8'h06, 16'h0001, 16'h0003, 16'h0B98, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h01, 8'h03, 16'h0000, 16'h0001, 16'h0A84, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h11, 8'h03, 16'h006B, 16'h0003, 16'h8776, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 8'h04, 16'h0000, 16'h0001, 16'hCA31, 1'b0, 1'b0, 1'b1};

        // Reset state, then the post-reset gap with a request already waiting.
        req_valid    = 1'b1;
        req_dev_addr = 8'h01;
        req_func     = 8'h03;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_crc", 32'(frame_crc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b1;
        gap_ref = cyc;
        ready_seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (req_ready) begin
                req_valid = 1'b0;
                ready_seen = 1'b1;
                chk("reset_gap", 32'(cyc - gap_ref), 32'(GAP));
                break;
            end
        end
        chk("ready_after_reset", 32'(ready_seen), 32'd1);
        chk("busy_in_idle", 32'(busy), 32'd0);
        $display("reset gap done at cycle %0d", cyc);

        dcyc = 0;
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].idle_pulse) begin
                repeat (5) @(negedge clk);
                tx_idle = 1'b0;
                repeat (5) @(negedge clk);
                tx_idle = 1'b1;
                gap_ref = cyc;
            end else begin
                gap_ref = dcyc;
            end
            run_frame(vecs[i], i > 0, gap_ref, 0, dcyc);
        end

        // Reset after the third byte handshake abandons the frame.
        pulses_before = done_pulses;
        run_frame(vecs[0], 1'b1, dcyc, 3, dcyc);
        rst_n = 1'b0;
        #1;
        chk("abort_tx_valid", 32'(tx_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        chk("abort_frame_crc", 32'(frame_crc), 32'd0);
        $display("reset asserted mid-frame at cycle %0d", cyc);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gap_ref = cyc;
        run_frame(vecs[1], 1'b1, gap_ref, 0, dcyc);
        chk("no_done_on_abort", 32'(done_pulses - pulses_before), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
